// File: rtl/pwm_multichannel.sv
// N-channel PWM generator with a shared prescaler and period counter.
// Settings are staged on a load strobe and applied only at a period boundary or while disabled.
module pwm_multichannel #(
  parameter int unsigned CHANNELS   = 3,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [PRESCALE_W-1:0]     prescale,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  input  logic [CHANNELS-1:0]       polarity,
  input  logic                      load,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      cycle_start,
  output logic                      pending
);

  logic [PRESCALE_W-1:0]     pre_cnt_q, pre_cnt_d;
  logic [WIDTH-1:0]          cnt_q, cnt_d;

  logic [PRESCALE_W-1:0]     prescale_stg_q, prescale_act_q;
  logic [WIDTH-1:0]          period_stg_q, period_act_q;
  logic [CHANNELS*WIDTH-1:0] duty_stg_q, duty_act_q;
  logic [CHANNELS-1:0]       pol_stg_q, pol_act_q;

  logic                      tick, wrap, apply;
  logic [CHANNELS-1:0]       pwm_d;

  always_comb begin
    tick  = en && (pre_cnt_q == prescale_act_q);
    wrap  = tick && (cnt_q == period_act_q);
    apply = pending && (wrap || !en);
  end

  // Disabled counters park at zero so a fresh enable starts a clean period.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    cnt_d     = cnt_q;
    if (!en) begin
      pre_cnt_d = '0;
      cnt_d     = '0;
    end else if (tick) begin
      pre_cnt_d = '0;
      cnt_d     = wrap ? '0 : cnt_q + 1'b1;
    end else begin
      pre_cnt_d = pre_cnt_q + 1'b1;
    end
  end

  always_comb begin
    pwm_d = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (en) begin
        pwm_d[i] = (cnt_q < duty_act_q[i*WIDTH +: WIDTH]) ^ pol_act_q[i];
      end else begin
        pwm_d[i] = pol_act_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q   <= '0;
      cnt_q       <= '0;
      pwm_out     <= '0;
      cycle_start <= 1'b0;
    end else begin
      pre_cnt_q   <= pre_cnt_d;
      cnt_q       <= cnt_d;
      pwm_out     <= pwm_d;
      cycle_start <= wrap;
    end
  end

  // Apply reads the old staging before a same-cycle load overwrites it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale_act_q <= '0;
      period_act_q   <= '0;
      duty_act_q     <= '0;
      pol_act_q      <= '0;
    end else if (apply) begin
      prescale_act_q <= prescale_stg_q;
      period_act_q   <= period_stg_q;
      duty_act_q     <= duty_stg_q;
      pol_act_q      <= pol_stg_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale_stg_q <= '0;
      period_stg_q   <= '0;
      duty_stg_q     <= '0;
      pol_stg_q      <= '0;
      pending        <= 1'b0;
    end else begin
      if (load) begin
        prescale_stg_q <= prescale;
        period_stg_q   <= period;
        duty_stg_q     <= duty;
        pol_stg_q      <= polarity;
        pending        <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Directed bench for pwm_multichannel: a cycle model feeds an expectation queue,
// plus window counts of high cycles, cycle_start pulses and pending.
module tb_pwm_multichannel;

  localparam int unsigned CH = 3;
  localparam int unsigned W  = 8;
  localparam int unsigned PW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [PW-1:0] prescale;
  logic [W-1:0]  period;
  logic [CH*W-1:0] duty;
  logic [CH-1:0] polarity;
  logic          load;
  logic [CH-1:0] pwm_out;
  logic          cycle_start;
  logic          pending;

  pwm_multichannel #(
    .CHANNELS  (CH),
    .WIDTH     (W),
    .PRESCALE_W(PW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .prescale   (prescale),
    .period     (period),
    .duty       (duty),
    .polarity   (polarity),
    .load       (load),
    .pwm_out    (pwm_out),
    .cycle_start(cycle_start),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  typedef logic [CH+1:0] obs_t;
  obs_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int hi_cnt[CH];
  int cs_cnt;
  int pend_cnt;

  // Reference model state
  logic [PW-1:0]   m_pre, m_pre_stg, m_pre_act;
  logic [W-1:0]    m_cnt, m_per_stg, m_per_act;
  logic [W-1:0]    m_duty_stg[CH], m_duty_act[CH];
  logic [CH-1:0]   m_pol_stg, m_pol_act;
  logic            m_pend;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pre = '0; m_pre_stg = '0; m_pre_act = '0;
    m_cnt = '0; m_per_stg = '0; m_per_act = '0;
    m_pol_stg = '0; m_pol_act = '0; m_pend = 1'b0;
    for (int i = 0; i < CH; i++) begin
      m_duty_stg[i] = '0;
      m_duty_act[i] = '0;
    end
    exp_q.delete();
  endtask

  task automatic model_step();
    logic tick, wrap, apply;
    logic [CH-1:0] npwm;
    tick  = en && (m_pre == m_pre_act);
    wrap  = tick && (m_cnt == m_per_act);
    apply = m_pend && (wrap || !en);
    for (int i = 0; i < CH; i++)
      npwm[i] = en ? ((m_cnt < m_duty_act[i]) != m_pol_act[i]) : m_pol_act[i];
    if (!en) begin
      m_pre = '0;
      m_cnt = '0;
    end else if (tick) begin
      m_pre = '0;
      m_cnt = wrap ? '0 : m_cnt + 1'b1;
    end else begin
      m_pre = m_pre + 1'b1;
    end
    if (apply) begin
      m_pre_act = m_pre_stg;
      m_per_act = m_per_stg;
      m_duty_act = m_duty_stg;
      m_pol_act = m_pol_stg;
      m_pend = 1'b0;
    end
    if (load) begin
      m_pre_stg = prescale;
      m_per_stg = period;
      for (int i = 0; i < CH; i++) m_duty_stg[i] = duty[i*W +: W];
      m_pol_stg = polarity;
      m_pend = 1'b1;
    end
    exp_q.push_back({npwm, wrap, m_pend});
  endtask

  function automatic logic about_to_wrap();
    return en && (m_pre == m_pre_act) && (m_cnt == m_per_act);
  endfunction

  task automatic clr_counts();
    for (int i = 0; i < CH; i++) hi_cnt[i] = 0;
    cs_cnt = 0;
    pend_cnt = 0;
  endtask

  task automatic cycle(input string tag);
    obs_t obs, exp;
    model_step();
    @(posedge clk);
    #1;
    obs = {pwm_out, cycle_start, pending};
    exp = exp_q.pop_front();
    check(tag, obs, exp);
    for (int i = 0; i < CH; i++) if (pwm_out[i]) hi_cnt[i]++;
    if (cycle_start) cs_cnt++;
    if (pending) pend_cnt++;
  endtask

  task automatic run(input string tag, input int n);
    for (int k = 0; k < n; k++) cycle(tag);
  endtask

  task automatic do_load(input logic [PW-1:0] p, input logic [W-1:0] per,
                         input logic [CH*W-1:0] d, input logic [CH-1:0] pol);
    prescale = p;
    period   = per;
    duty     = d;
    polarity = pol;
    load     = 1'b1;
    cycle("load");
    load     = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0;
    prescale = '0; period = '0; duty = '0; polarity = '0;
    model_reset();
    clr_counts();
    #1;
    check("reset_init", {pwm_out, cycle_start, pending}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run("idle", 2);

    // Basic duty: ch0 2/10, ch1 5/10, ch2 always high, cycle_start every 10 clk
    do_load(16'd0, 8'd9, {8'd10, 8'd5, 8'd2}, 3'b000);
    check("pend_after_load", pending, 1);
    cycle("apply_disabled");
    check("pend_applied_disabled", pending, 0);
    en = 1'b1;
    clr_counts();
    run("basic", 20);
    check("basic_ch0_hi", hi_cnt[0], 4);
    check("basic_ch1_hi", hi_cnt[1], 10);
    check("basic_ch2_hi", hi_cnt[2], 20);
    check("basic_cs", cs_cnt, 2);

    // Glitch-free update: load at cnt=4, current period keeps 2/10
    clr_counts();
    run("glitch_pre", 4);
    do_load(16'd0, 8'd9, {8'd10, 8'd5, 8'd7}, 3'b000);
    check("glitch_pend_set", pending, 1);
    run("glitch_rest", 5);
    check("glitch_old_ch0", hi_cnt[0], 2);
    check("glitch_pend_cleared", pending, 0);
    clr_counts();
    run("glitch_new", 10);
    check("glitch_new_ch0", hi_cnt[0], 7);
    check("glitch_new_cs", cs_cnt, 1);

    // Prescale 3: steps of 4 clk, period of 40 clk
    do_load(16'd3, 8'd9, {8'd10, 8'd5, 8'd7}, 3'b000);
    run("pre_wait", 9);
    check("pre_pend_cleared", pending, 0);
    clr_counts();
    run("prescale", 80);
    check("pre_ch0_hi", hi_cnt[0], 56);
    check("pre_ch1_hi", hi_cnt[1], 40);
    check("pre_ch2_hi", hi_cnt[2], 80);
    check("pre_cs", cs_cnt, 2);

    // Polarity and disable
    en = 1'b0;
    cycle("disable");
    do_load(16'd0, 8'd9, {8'd10, 8'd5, 8'd0}, 3'b001);
    cycle("pol_apply");
    cycle("pol_settle");
    check("pol_disabled_out", pwm_out, 3'b001);
    check("pol_disabled_cs", cycle_start, 0);
    en = 1'b1;
    clr_counts();
    run("pol_run", 20);
    check("pol_ch0_hi", hi_cnt[0], 20);
    check("pol_ch1_hi", hi_cnt[1], 10);
    check("pol_cs", cs_cnt, 2);

    // Load in the same clk as a wrap
    do_load(16'd0, 8'd9, {8'd10, 8'd5, 8'd3}, 3'b000);
    for (int k = 0; k < 40 && !about_to_wrap(); k++) cycle("seek_wrap");
    do_load(16'd0, 8'd9, {8'd10, 8'd5, 8'd6}, 3'b000);
    check("law_pend_at_wrap", pending, 1);
    clr_counts();
    run("law_mid", 9);
    check("law_pend_held", pend_cnt, 9);
    cycle("law_wrap");
    check("law_pend_cleared", pending, 0);
    check("law_prev_ch0", hi_cnt[0], 3);
    clr_counts();
    run("law_next", 10);
    check("law_new_ch0", hi_cnt[0], 6);

    // Reset mid-operation with settings pending
    do_load(16'd2, 8'd4, {8'd1, 8'd1, 8'd1}, 3'b111);
    run("pre_reset", 3);
    #3;
    rst = 1'b1;
    #1;
    check("reset_mid", {pwm_out, cycle_start, pending}, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    run("post_reset", 6);
    check("post_reset_pend", pending, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
